turn_timer: RTL and testbench

Turn countdown controller that sits directly downstream of the free-running cycle `counter`. It consumes the counter's 32-bit `q` value and drives that counter's `reset` input, so that one "second" is exactly `CYCLES_PER_TICK` clocks. It counts a player's turn down from `TURN_SECONDS` and reports per-second ticks, the remaining time, and a timeout event to the game FSM.

---
 rtl/turn_timer.sv | 123 ++++++++++++
 tb/tb_turn_timer.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/turn_timer.sv
// turn_timer: per-turn countdown driven by an external free-running cycle counter.
// One second-tick is CYCLES_PER_TICK clocks of uninterrupted RUN time.
// Ports:
//   clk, reset    - clock and synchronous active-high reset
//   count         - signed q value of the upstream counter
//   start         - load TURN_SECONDS and run (any state)
//   move_done     - stop the turn, keep seconds_left for scoring
//   pause         - level; hold the countdown while high
//   cnt_reset     - combinational reset request to the upstream counter
//   seconds_left  - remaining whole seconds
//   running       - high while in RUN
//   tick          - one-cycle pulse per elapsed second
//   timeout       - one-cycle pulse when the turn runs out
//   expired       - level from timeout until next start/reset
module turn_timer #(
    parameter int unsigned CYCLES_PER_TICK = 50_000_000,
    parameter int unsigned TURN_SECONDS    = 15,
    parameter int unsigned SW              = $clog2(TURN_SECONDS + 1)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic signed [31:0]   count,
    input  logic                 start,
    input  logic                 move_done,
    input  logic                 pause,
    output logic                 cnt_reset,
    output logic [SW-1:0]        seconds_left,
    output logic                 running,
    output logic                 tick,
    output logic                 timeout,
    output logic                 expired
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_RUN     = 2'd1;
    localparam logic [1:0] S_PAUSED  = 2'd2;
    localparam logic [1:0] S_EXPIRED = 2'd3;

    localparam logic signed [31:0] TC_LIMIT  = 32'(CYCLES_PER_TICK - 1);
    localparam logic [SW-1:0]      SEC_LOAD  = SW'(TURN_SECONDS);
    localparam logic [SW-1:0]      SEC_ONE   = SW'(1);

    logic [1:0]    state;
    logic [1:0]    state_n;
    logic [SW-1:0] seconds_n;
    logic          running_n;
    logic          tick_n;
    logic          timeout_n;
    logic          expired_n;
    logic          tc;

    // A full second has elapsed in RUN with nothing overriding it; signed compare
    assign tc = (state == S_RUN) && !start && !move_done && !pause
                && (count >= TC_LIMIT);

    // Counter restarts whenever the current second is not being accumulated
    assign cnt_reset = (state != S_RUN) | start | move_done | pause | tc;

    // State and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= S_IDLE;
            seconds_left <= '0;
            running      <= 1'b0;
            tick         <= 1'b0;
            timeout      <= 1'b0;
            expired      <= 1'b0;
        end else begin
            state        <= state_n;
            seconds_left <= seconds_n;
            running      <= running_n;
            tick         <= tick_n;
            timeout      <= timeout_n;
            expired      <= expired_n;
        end
    end

    // Next state and next outputs; priority start > move_done > pause > tc
    always_comb begin
        state_n   = state;
        seconds_n = seconds_left;
        tick_n    = 1'b0;
        timeout_n = 1'b0;
        expired_n = expired;

        if (start) begin
            state_n   = S_RUN;
            seconds_n = SEC_LOAD;
            expired_n = 1'b0;
        end else if (move_done && (state == S_RUN || state == S_PAUSED)) begin
            state_n = S_IDLE;
        end else begin
            case (state)
                S_RUN: begin
                    if (pause) begin
                        state_n = S_PAUSED;
                    end else if (tc) begin
                        tick_n = 1'b1;
                        if (seconds_left > SEC_ONE) begin
                            seconds_n = seconds_left - SEC_ONE;
                        end else begin
                            seconds_n = '0;
                            state_n   = S_EXPIRED;
                            timeout_n = 1'b1;
                            expired_n = 1'b1;
                        end
                    end
                end
                S_PAUSED: begin
                    if (!pause) begin
                        state_n = S_RUN;
                    end
                end
                default: begin
                    state_n = state;
                end
            endcase
        end

        running_n = (state_n == S_RUN);
    end

endmodule

// File: tb/tb_turn_timer.sv
// Self-checking bench for turn_timer with a behavioural free-running counter
// and a time-based reference model (elapsed run cycles per second).
module tb_turn_timer;

    localparam int CPT = 4;
    localparam int TS  = 3;

    localparam int M_IDLE    = 0;
    localparam int M_RUN     = 1;
    localparam int M_PAUSED  = 2;
    localparam int M_EXPIRED = 3;

    logic               clk;
    logic               reset;
    logic signed [31:0] count;
    logic               start;
    logic               move_done;
    logic               pause;
    logic               cnt_reset;
    logic [1:0]         seconds_left;
    logic               running;
    logic               tick;
    logic               timeout;
    logic               expired;

    int n_checks;
    int n_errors;

    // reference model state
    int  m_mode;
    int  m_secs;
    int  m_elapsed;
    bit  m_tick;
    bit  m_timeout;
    bit  m_expired;
    bit  armed;
    int  tick_count;
    int  timeout_count;

    turn_timer #(
        .CYCLES_PER_TICK (CPT),
        .TURN_SECONDS    (TS)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .count        (count),
        .start        (start),
        .move_done    (move_done),
        .pause        (pause),
        .cnt_reset    (cnt_reset),
        .seconds_left (seconds_left),
        .running      (running),
        .tick         (tick),
        .timeout      (timeout),
        .expired      (expired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Upstream free-running counter whose reset is driven by the DUT
    initial count = 32'sd0;
    always @(posedge clk) begin
        if (cnt_reset) count <= 32'sd0;
        else           count <= count + 32'sd1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance the model across one clock edge using the inputs seen at that edge
    task automatic model_edge(input bit rst, input bit st, input bit md, input bit ps);
        m_tick    = 1'b0;
        m_timeout = 1'b0;
        if (rst) begin
            m_mode = M_IDLE; m_secs = 0; m_elapsed = 0; m_expired = 1'b0;
        end else if (st) begin
            m_mode = M_RUN; m_secs = TS; m_elapsed = 0; m_expired = 1'b0;
        end else if (md && (m_mode == M_RUN || m_mode == M_PAUSED)) begin
            m_mode = M_IDLE; m_elapsed = 0;
        end else if (m_mode == M_RUN && ps) begin
            m_mode = M_PAUSED; m_elapsed = 0;
        end else if (m_mode == M_PAUSED && !ps) begin
            m_mode = M_RUN; m_elapsed = 0;
        end else if (m_mode == M_RUN) begin
            m_elapsed++;
            if (m_elapsed == CPT) begin
                m_elapsed = 0;
                m_tick    = 1'b1;
                m_secs--;
                if (m_secs == 0) begin
                    m_mode    = M_EXPIRED;
                    m_timeout = 1'b1;
                    m_expired = 1'b1;
                end
            end
        end else begin
            m_elapsed = 0;
        end
    endtask

    // One clock cycle: drive inputs, check the combinational output, clock, check registers
    task automatic step(input bit rst, input bit st, input bit md, input bit ps);
        bit exp_cr;
        reset = rst; start = st; move_done = md; pause = ps;
        #3;
        if (armed) begin
            exp_cr = (m_mode != M_RUN) || st || md || ps ||
                     (m_mode == M_RUN && m_elapsed == CPT - 1);
            check("cnt_reset", 32'(cnt_reset), 32'(exp_cr));
        end
        @(posedge clk);
        model_edge(rst, st, md, ps);
        if (rst) armed = 1'b1;
        #1;
        if (armed) begin
            check("seconds_left", 32'(seconds_left), 32'(m_secs));
            check("running",      32'(running),      32'(m_mode == M_RUN));
            check("tick",         32'(tick),         32'(m_tick));
            check("timeout",      32'(timeout),      32'(m_timeout));
            check("expired",      32'(expired),      32'(m_expired));
        end
        if (tick)    tick_count++;
        if (timeout) timeout_count++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        bit ps_level;
        n_checks = 0; n_errors = 0; armed = 1'b0;
        tick_count = 0; timeout_count = 0;
        m_mode = M_IDLE; m_secs = 0; m_elapsed = 0;
        m_tick = 0; m_timeout = 0; m_expired = 0;
        reset = 1'b1; start = 1'b0; move_done = 1'b0; pause = 1'b0;
        @(posedge clk); #1;

        // reset for two cycles
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        check("reset_cnt_reset", 32'(cnt_reset), 32'd1);

        // full countdown: ticks at E+4, E+8, timeout at E+12
        tick_count = 0; timeout_count = 0;
        step(1'b0, 1'b1, 1'b0, 1'b0);
        idle(14);
        check("full_ticks",    32'(tick_count),    32'd3);
        check("full_timeouts", 32'(timeout_count), 32'd1);
        check("full_expired",  32'(expired),       32'd1);

        // move_done at E+6 holds seconds_left=2
        tick_count = 0; timeout_count = 0;
        step(1'b0, 1'b1, 1'b0, 1'b0);
        idle(5);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        idle(12);
        check("move_hold_secs", 32'(seconds_left),  32'd2);
        check("move_timeouts",  32'(timeout_count), 32'd0);

        // pause high E+2..E+6, released at E+7, next tick at E+11
        step(1'b0, 1'b1, 1'b0, 1'b0);
        idle(1);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b0, 1'b1);
        check("pause_secs", 32'(seconds_left), 32'd3);
        idle(16);

        // restart at E+9 while seconds_left=1
        step(1'b0, 1'b1, 1'b0, 1'b0);
        idle(8);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        idle(14);

        // pause on the tc edge (E+4): no decrement
        step(1'b0, 1'b1, 1'b0, 1'b0);
        idle(3);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        check("pause_tc_secs", 32'(seconds_left), 32'd3);
        idle(6);

        // reset mid-run
        step(1'b0, 1'b1, 1'b0, 1'b0);
        idle(5);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        check("midrun_reset_running", 32'(running), 32'd0);
        idle(3);

        // start while expired
        step(1'b0, 1'b1, 1'b0, 1'b0);
        idle(13);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        check("restart_expired", 32'(expired), 32'd0);
        idle(14);

        // randomized traffic
        ps_level = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            bit r, s, m;
            if ($urandom_range(99) < 8) ps_level = ~ps_level;
            r = ($urandom_range(199) == 0);
            s = ($urandom_range(99) < 3);
            m = ($urandom_range(99) < 3);
            step(r, s, m, ps_level);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
